coeff_write_initiator: RTL and testbench



---
 rtl/coeff_write_initiator_pkg.sv | 26 ++
 rtl/coeff_write_initiator_ack_timer.sv | 51 +++++
 rtl/coeff_write_initiator.sv | 184 ++++++++++++++++++
 tb/tb_coeff_write_initiator.sv | 389 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/coeff_write_initiator_pkg.sv
// coeff_write_initiator_pkg
// Shared constants and FSM encoding for the coefficient write initiator.
//   CWI_NUM_CH_PER_LANE   : coefficients per set (one write per channel)
//   CWI_COEFF_WIDTH       : width of each I and Q half
//   CWI_COEFF_ADDR_WIDTH  : write address width
//   CWI_ACK_TIMEOUT       : default cycles to wait for an ack per attempt
//   CWI_MAX_RETRY         : default retries after the first attempt
//   cwi_state_t           : FSM state encoding (CWI_ST_*)
package coeff_write_initiator_pkg;

  localparam int CWI_NUM_CH_PER_LANE  = 24;
  localparam int CWI_COEFF_WIDTH      = 16;
  localparam int CWI_COEFF_ADDR_WIDTH = 5;
  localparam int CWI_ACK_TIMEOUT      = 64;
  localparam int CWI_MAX_RETRY        = 3;

  typedef enum logic [2:0] {
    CWI_ST_IDLE  = 3'd0,
    CWI_ST_FETCH = 3'd1,
    CWI_ST_WRITE = 3'd2,
    CWI_ST_GAP   = 3'd3,
    CWI_ST_DONE  = 3'd4,
    CWI_ST_ERROR = 3'd5
  } cwi_state_t;

endpackage

// File: rtl/coeff_write_initiator_ack_timer.sv
// coeff_ack_timer
// Per-attempt ack timeout counter plus retry counter for the coefficient
// write initiator. Only present when COEFF_WR_TIMEOUT_EN is defined.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   clear      : new word accepted; zero both counters
//   tick       : one WRITE cycle passed without an ack
//   retry      : start another attempt; zero timer, bump retry count
//   expire     : this tick is the last cycle of the current attempt
//   exhausted  : all retries have been used up
`ifdef COEFF_WR_TIMEOUT_EN
module coeff_ack_timer #(
  parameter int ACK_TIMEOUT = 64,
  parameter int MAX_RETRY   = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic tick,
  input  logic retry,
  output logic expire,
  output logic exhausted
);

  localparam int TW = $clog2(ACK_TIMEOUT + 1);
  localparam int RW = $clog2(MAX_RETRY + 2);

  logic [TW-1:0] tcnt;
  logic [RW-1:0] rcnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tcnt <= '0;
      rcnt <= '0;
    end else if (clear) begin
      tcnt <= '0;
      rcnt <= '0;
    end else if (retry) begin
      // retry coincides with the expiring tick; the new attempt starts at zero
      tcnt <= '0;
      rcnt <= rcnt + 1'b1;
    end else if (tick) begin
      tcnt <= tcnt + 1'b1;
    end
  end

  assign expire    = tick && (tcnt == TW'(ACK_TIMEOUT - 1));
  assign exhausted = (rcnt == RW'(MAX_RETRY));

endmodule
`endif

// File: rtl/coeff_write_initiator.sv
// coeff_write_initiator
// Fetches a coefficient set from a ready/valid source and issues one write
// per channel (address 0..NUM_CH-1), holding each write until acked.
// Optional feature macro: COEFF_WR_TIMEOUT_EN (ack timeout with bounded
// retry; without it WRITE waits for ack forever and error_o stays 0).
// Ports:
//   axi_clk, axi_rst : clock, asynchronous active-high reset
//   load_start_i     : pulse that starts loading a set (ignored when busy)
//   coeff_data_i     : {Q,I} source word
//   coeff_valid_i    : source word valid
//   coeff_ready_o    : high in FETCH; word taken when valid && ready
//   axi_addr         : write address
//   axi_data_w       : write data
//   axi_we           : write request, held until axi_ack
//   axi_ack          : responder completion (ignored while axi_we is low)
//   busy_o           : load in progress
//   done_o           : one-cycle pulse when the whole set is written
//   error_o          : sticky timeout error, cleared by next load_start_i
//   words_written_o  : acked writes in the current or last load
module coeff_write_initiator
  import coeff_write_initiator_pkg::*;
#(
  parameter int NUM_CH      = CWI_NUM_CH_PER_LANE,
  parameter int COEFF_WIDTH = CWI_COEFF_WIDTH,
  parameter int ADDR_WIDTH  = CWI_COEFF_ADDR_WIDTH
`ifdef COEFF_WR_TIMEOUT_EN
  ,
  parameter int ACK_TIMEOUT = CWI_ACK_TIMEOUT,
  parameter int MAX_RETRY   = CWI_MAX_RETRY
`endif
) (
  input  logic                     axi_clk,
  input  logic                     axi_rst,
  input  logic                     load_start_i,
  input  logic [2*COEFF_WIDTH-1:0] coeff_data_i,
  input  logic                     coeff_valid_i,
  output logic                     coeff_ready_o,
  output logic [ADDR_WIDTH-1:0]    axi_addr,
  output logic [2*COEFF_WIDTH-1:0] axi_data_w,
  output logic                     axi_we,
  input  logic                     axi_ack,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     error_o,
  output logic [7:0]               words_written_o
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_CH - 1);

  cwi_state_t            state;
  logic [ADDR_WIDTH-1:0] addr_cnt;
  logic                  accept;

  assign accept = (state == CWI_ST_FETCH) && coeff_valid_i && coeff_ready_o;

`ifdef COEFF_WR_TIMEOUT_EN
  logic tick;
  logic retry;
  logic expire;
  logic exhausted;
  // set when GAP is the pause between two attempts of the same word
  logic retry_gap;

  assign tick  = (state == CWI_ST_WRITE) && !axi_ack;
  assign retry = expire && !exhausted;

  coeff_ack_timer #(
    .ACK_TIMEOUT(ACK_TIMEOUT),
    .MAX_RETRY  (MAX_RETRY)
  ) u_ack_timer (
    .clk      (axi_clk),
    .rst      (axi_rst),
    .clear    (accept),
    .tick     (tick),
    .retry    (retry),
    .expire   (expire),
    .exhausted(exhausted)
  );
`endif

  always_ff @(posedge axi_clk or posedge axi_rst) begin
    if (axi_rst) begin
      state           <= CWI_ST_IDLE;
      addr_cnt        <= '0;
      axi_addr        <= '0;
      axi_data_w      <= '0;
      axi_we          <= 1'b0;
      coeff_ready_o   <= 1'b0;
      busy_o          <= 1'b0;
      done_o          <= 1'b0;
      error_o         <= 1'b0;
      words_written_o <= '0;
`ifdef COEFF_WR_TIMEOUT_EN
      retry_gap       <= 1'b0;
`endif
    end else begin
      done_o <= 1'b0;
      case (state)
        CWI_ST_IDLE: begin
          if (load_start_i) begin
            words_written_o <= '0;
            addr_cnt        <= '0;
            error_o         <= 1'b0;
            coeff_ready_o   <= 1'b1;
            busy_o          <= 1'b1;
            state           <= CWI_ST_FETCH;
          end
        end

        CWI_ST_FETCH: begin
          if (accept) begin
            axi_data_w    <= coeff_data_i;
            axi_addr      <= addr_cnt;
            axi_we        <= 1'b1;
            coeff_ready_o <= 1'b0;
            state         <= CWI_ST_WRITE;
          end
        end

        CWI_ST_WRITE: begin
          if (axi_ack) begin
            axi_we          <= 1'b0;
            words_written_o <= words_written_o + 8'd1;
            if (axi_addr == LAST_ADDR) begin
              // counter stays at the last address so it never wraps
              done_o <= 1'b1;
              state  <= CWI_ST_DONE;
            end else begin
              addr_cnt <= addr_cnt + 1'b1;
              state    <= CWI_ST_GAP;
            end
          end
`ifdef COEFF_WR_TIMEOUT_EN
          else if (expire) begin
            axi_we <= 1'b0;
            if (exhausted) begin
              error_o <= 1'b1;
              state   <= CWI_ST_ERROR;
            end else begin
              retry_gap <= 1'b1;
              state     <= CWI_ST_GAP;
            end
          end
`endif
        end

        CWI_ST_GAP: begin
`ifdef COEFF_WR_TIMEOUT_EN
          if (retry_gap) begin
            // re-issue the same address and data after the one-cycle drop
            retry_gap <= 1'b0;
            axi_we    <= 1'b1;
            state     <= CWI_ST_WRITE;
          end else begin
            coeff_ready_o <= 1'b1;
            state         <= CWI_ST_FETCH;
          end
`else
          coeff_ready_o <= 1'b1;
          state         <= CWI_ST_FETCH;
`endif
        end

        CWI_ST_DONE: begin
          busy_o <= 1'b0;
          state  <= CWI_ST_IDLE;
        end

        CWI_ST_ERROR: begin
          busy_o <= 1'b0;
          state  <= CWI_ST_IDLE;
        end

        default: begin
          axi_we        <= 1'b0;
          coeff_ready_o <= 1'b0;
          busy_o        <= 1'b0;
          state         <= CWI_ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_coeff_write_initiator.sv
// tb_coeff_write_initiator
// Randomized self-checking bench for coeff_write_initiator. A behavioural
// source/responder drives the DUT each falling edge; observed writes are
// compared with the set of words the source offered, in channel order.
// Timeout scenarios are built only when COEFF_WR_TIMEOUT_EN is defined.
module tb_coeff_write_initiator;

  localparam int NCH = 24;
  localparam int CW  = 16;
  localparam int AW  = 5;

  logic          axi_clk = 1'b0;
  logic          axi_rst = 1'b1;
  logic          load_start_i = 1'b0;
  logic [2*CW-1:0] coeff_data_i = '0;
  logic          coeff_valid_i = 1'b0;
  logic          coeff_ready_o;
  logic [AW-1:0] axi_addr;
  logic [2*CW-1:0] axi_data_w;
  logic          axi_we;
  logic          axi_ack = 1'b0;
  logic          busy_o;
  logic          done_o;
  logic          error_o;
  logic [7:0]    words_written_o;

  always #5 axi_clk = ~axi_clk;

`ifdef COEFF_WR_TIMEOUT_EN
  coeff_write_initiator #(
    .NUM_CH(NCH), .COEFF_WIDTH(CW), .ADDR_WIDTH(AW),
    .ACK_TIMEOUT(8), .MAX_RETRY(2)
  ) dut (
`else
  coeff_write_initiator #(
    .NUM_CH(NCH), .COEFF_WIDTH(CW), .ADDR_WIDTH(AW)
  ) dut (
`endif
    .axi_clk        (axi_clk),
    .axi_rst        (axi_rst),
    .load_start_i   (load_start_i),
    .coeff_data_i   (coeff_data_i),
    .coeff_valid_i  (coeff_valid_i),
    .coeff_ready_o  (coeff_ready_o),
    .axi_addr       (axi_addr),
    .axi_data_w     (axi_data_w),
    .axi_we         (axi_we),
    .axi_ack        (axi_ack),
    .busy_o         (busy_o),
    .done_o         (done_o),
    .error_o        (error_o),
    .words_written_o(words_written_o)
  );

  int errors = 0;
  int checks = 0;

  // source contents and observations of the most recent load
  logic [2*CW-1:0] src_words [NCH];
  int              wr_addr_q [$];
  logic [2*CW-1:0] wr_data_q [$];
  int              att_addr_q [$];
  int              att_len_q [$];
  int              att_start_q [$];
  int done_cnt, first_we_cyc, hold_bad, ready_in_we, gap_bad, done_seq_bad;
  int cycles;
  bit timed_out;

  task automatic fill_src(input bit counting);
    for (int i = 0; i < NCH; i++)
      src_words[i] = counting ? (32'h0001_0000 + 32'(i)) : 32'($urandom);
  endtask

  // Runs one load. Source: always valid, or valid on ~1 of 5 random cycles.
  // Responder acks after d extra cycles of axi_we (random 0..3 if rand_ack),
  // uses slow_d on slow_addr, never acks dead_addr, and pulses load_start_i
  // on the first write cycle of restart_addr.
  task automatic run_load(input bit gapped, input bit rand_ack, input int base_d,
                          input int slow_addr, input int slow_d, input int dead_addr,
                          input int restart_addr, input int budget);
    int ptr, run, stage, d;
    bit prev_we, acked_prev, a, v;
    logic [AW-1:0]   a_addr;
    logic [2*CW-1:0] a_data;
    wr_addr_q.delete(); wr_data_q.delete();
    att_addr_q.delete(); att_len_q.delete(); att_start_q.delete();
    done_cnt = 0; first_we_cyc = -1; hold_bad = 0; ready_in_we = 0;
    gap_bad = 0; done_seq_bad = 0;
    ptr = 0; run = 0; stage = 0; d = base_d; prev_we = 0; acked_prev = 0;
    a_addr = '0; a_data = '0;
    @(negedge axi_clk);
    load_start_i  = 1'b1;
    coeff_valid_i = !gapped;
    coeff_data_i  = src_words[0];
    axi_ack       = 1'b0;
    @(negedge axi_clk);
    load_start_i = 1'b0;
    for (cycles = 0; cycles < budget; cycles++) begin
      if (done_o) done_cnt++;
      if (coeff_ready_o && axi_we) ready_in_we++;
      case (stage)
        1: begin if (axi_we || coeff_ready_o || !busy_o) gap_bad++; stage = 2; end
        2: begin if (axi_we || !coeff_ready_o) gap_bad++; stage = 0; end
        3: begin if (!done_o || axi_we || !busy_o) done_seq_bad++; stage = 4; end
        4: begin if (done_o || busy_o) done_seq_bad++; stage = 0; end
        default: ;
      endcase
      if (!busy_o && stage == 0) break;
      if (axi_we) begin
        if (!prev_we) begin
          run = 0; a_addr = axi_addr; a_data = axi_data_w;
          att_addr_q.push_back(int'(axi_addr));
          att_start_q.push_back(cycles);
          if (first_we_cyc < 0) first_we_cyc = cycles;
          d = (int'(axi_addr) == slow_addr) ? slow_d :
              (rand_ack ? int'($urandom_range(0, 3)) : base_d);
        end else begin
          run++;
          if (axi_addr !== a_addr || axi_data_w !== a_data) hold_bad++;
        end
      end else if (prev_we && !acked_prev) begin
        att_len_q.push_back(run + 1);
      end
      a = axi_we && (int'(axi_addr) != dead_addr) && (run >= d);
      if (a) begin
        wr_addr_q.push_back(int'(axi_addr));
        wr_data_q.push_back(axi_data_w);
        att_len_q.push_back(run + 1);
        stage = (int'(axi_addr) == NCH - 1) ? 3 : 1;
      end
      load_start_i = axi_we && !prev_we && (int'(axi_addr) == restart_addr);
      axi_ack    = a;
      acked_prev = a;
      prev_we    = axi_we;
      v = gapped ? ($urandom_range(0, 4) == 0) : 1'b1;
      coeff_valid_i = v;
      coeff_data_i  = (ptr < NCH) ? src_words[ptr] : 32'hDEAD_BEEF;
      if (coeff_ready_o && v) ptr++;
      @(negedge axi_clk);
    end
    timed_out     = (cycles >= budget);
    axi_ack       = 1'b0;
    coeff_valid_i = 1'b0;
    load_start_i  = 1'b0;
  endtask

  task automatic test_reset();
    axi_rst = 1'b1;
    repeat (3) @(negedge axi_clk);
    checks++;
    if ({axi_we, coeff_ready_o, busy_o, done_o, error_o} !== 5'b0) begin
      errors++; $display("FAIL reset_ctl: got %b want 00000",
                         {axi_we, coeff_ready_o, busy_o, done_o, error_o});
    end
    checks++;
    if (axi_addr !== '0 || axi_data_w !== '0 || words_written_o !== 8'd0) begin
      errors++; $display("FAIL reset_data: addr=%0h data=%0h words=%0d want 0",
                         axi_addr, axi_data_w, words_written_o);
    end
    axi_rst = 1'b0;
    repeat (2) @(negedge axi_clk);
    checks++;
    if (busy_o !== 1'b0 || axi_we !== 1'b0) begin
      errors++; $display("FAIL idle_after_reset: busy=%b we=%b want 0 0", busy_o, axi_we);
    end
  endtask

  task automatic test_full_set();
    int bad;
    fill_src(1'b1);
    run_load(1'b0, 1'b0, 1, -1, 0, -1, -1, 400);
    checks++;
    if (timed_out) begin errors++; $display("FAIL full_timeout: load did not finish"); end
    checks++;
    if (wr_addr_q.size() !== NCH) begin
      errors++; $display("FAIL full_count: got %0d writes want %0d", wr_addr_q.size(), NCH);
    end
    bad = 0;
    for (int i = 0; i < wr_addr_q.size() && i < NCH; i++)
      if (wr_addr_q[i] !== i || wr_data_q[i] !== src_words[i]) bad++;
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL full_writes: %0d wrong addr/data, want 0", bad); end
    checks++;
    if (done_cnt !== 1) begin errors++; $display("FAIL full_done: got %0d pulses want 1", done_cnt); end
    checks++;
    if (words_written_o !== 8'd24) begin
      errors++; $display("FAIL full_words: got %0d want 24", words_written_o);
    end
    checks++;
    if (error_o !== 1'b0) begin errors++; $display("FAIL full_error: got %b want 0", error_o); end
    checks++;
    if (first_we_cyc !== 1) begin
      errors++; $display("FAIL start_latency: first we at %0d want 1", first_we_cyc);
    end
    checks++;
    if (gap_bad !== 0 || done_seq_bad !== 0 || hold_bad !== 0) begin
      errors++; $display("FAIL full_seq: gap=%0d done=%0d hold=%0d want 0 0 0",
                         gap_bad, done_seq_bad, hold_bad);
    end
  endtask

  task automatic test_back_to_back();
    fill_src(1'b0);
    run_load(1'b0, 1'b0, 0, -1, 0, -1, -1, 400);
    checks++;
    if (cycles !== 72) begin
      errors++; $display("FAIL b2b_cycles: idle %0d edges after start want 73", cycles + 1);
    end
    checks++;
    if (wr_addr_q.size() !== NCH || done_cnt !== 1) begin
      errors++; $display("FAIL b2b_count: writes=%0d done=%0d want %0d 1",
                         wr_addr_q.size(), done_cnt, NCH);
    end
  endtask

  task automatic test_gapped();
    int bad;
    fill_src(1'b0);
    run_load(1'b1, 1'b1, 0, -1, 0, -1, -1, 3000);
    checks++;
    if (timed_out) begin errors++; $display("FAIL gapped_timeout: load did not finish"); end
    bad = 0;
    for (int i = 0; i < wr_addr_q.size() && i < NCH; i++)
      if (wr_addr_q[i] !== i || wr_data_q[i] !== src_words[i]) bad++;
    checks++;
    if (bad !== 0 || wr_addr_q.size() !== NCH) begin
      errors++; $display("FAIL gapped_order: writes=%0d wrong=%0d want %0d 0",
                         wr_addr_q.size(), bad, NCH);
    end
    checks++;
    if (att_addr_q.size() !== NCH) begin
      errors++; $display("FAIL gapped_we_count: got %0d we bursts want %0d", att_addr_q.size(), NCH);
    end
    checks++;
    if (ready_in_we !== 0 || gap_bad !== 0) begin
      errors++; $display("FAIL gapped_ready: ready_in_we=%0d gap=%0d want 0 0", ready_in_we, gap_bad);
    end
    checks++;
    if (done_cnt !== 1 || words_written_o !== 8'd24) begin
      errors++; $display("FAIL gapped_done: done=%0d words=%0d want 1 24", done_cnt, words_written_o);
    end
  endtask

  task automatic test_delayed_ack();
    int len7;
    fill_src(1'b0);
    run_load(1'b0, 1'b0, 0, 7, 9, -1, -1, 500);
    len7 = -1;
    for (int i = 0; i < att_addr_q.size() && i < att_len_q.size(); i++)
      if (att_addr_q[i] == 7) len7 = att_len_q[i];
    checks++;
    if (len7 !== 10) begin errors++; $display("FAIL slow_hold_len: got %0d cycles want 10", len7); end
    checks++;
    if (hold_bad !== 0) begin errors++; $display("FAIL slow_stable: %0d changes want 0", hold_bad); end
    checks++;
    if (gap_bad !== 0) begin errors++; $display("FAIL slow_gap: %0d bad gaps want 0", gap_bad); end
    checks++;
    if (wr_addr_q.size() !== NCH || words_written_o !== 8'd24 || done_cnt !== 1) begin
      errors++; $display("FAIL slow_total: writes=%0d words=%0d done=%0d want 24 24 1",
                         wr_addr_q.size(), words_written_o, done_cnt);
    end
  endtask

`ifdef COEFF_WR_TIMEOUT_EN
  task automatic test_timeout();
    int n3, badlen, badgap, prev_end;
    fill_src(1'b0);
    run_load(1'b0, 1'b0, 0, -1, 0, 3, -1, 500);
    n3 = 0; badlen = 0; badgap = 0; prev_end = -1;
    for (int i = 0; i < att_addr_q.size() && i < att_len_q.size(); i++) begin
      if (att_addr_q[i] == 3) begin
        n3++;
        if (att_len_q[i] != 8) badlen++;
        if (prev_end >= 0 && att_start_q[i] - prev_end != 1) badgap++;
        prev_end = att_start_q[i] + att_len_q[i];
      end
    end
    checks++;
    if (n3 !== 3) begin errors++; $display("FAIL to_attempts: got %0d want 3", n3); end
    checks++;
    if (badlen !== 0 || badgap !== 0) begin
      errors++; $display("FAIL to_shape: bad lengths=%0d bad gaps=%0d want 0 0", badlen, badgap);
    end
    checks++;
    if (error_o !== 1'b1 || done_cnt !== 0 || words_written_o !== 8'd3) begin
      errors++; $display("FAIL to_result: error=%b done=%0d words=%0d want 1 0 3",
                         error_o, done_cnt, words_written_o);
    end
    checks++;
    if (timed_out || busy_o !== 1'b0) begin
      errors++; $display("FAIL to_exit: timed_out=%b busy=%b want 0 0", timed_out, busy_o);
    end
    run_load(1'b0, 1'b1, 0, -1, 0, -1, -1, 500);
    checks++;
    if (error_o !== 1'b0 || done_cnt !== 1 || words_written_o !== 8'd24) begin
      errors++; $display("FAIL to_recover: error=%b done=%0d words=%0d want 0 1 24",
                         error_o, done_cnt, words_written_o);
    end
  endtask
`endif

  task automatic test_reset_mid_load();
    bit found;
    found = 1'b0;
    fill_src(1'b0);
    @(negedge axi_clk);
    load_start_i = 1'b1; coeff_valid_i = 1'b1; coeff_data_i = src_words[0];
    @(negedge axi_clk);
    load_start_i = 1'b0;
    for (int c = 0; c < 200; c++) begin
      if (axi_we && axi_addr == AW'(12)) begin found = 1'b1; break; end
      axi_ack = axi_we;
      @(negedge axi_clk);
    end
    axi_ack = 1'b0;
    checks++;
    if (!found) begin errors++; $display("FAIL rst_reach12: address 12 write not seen want seen"); end
    #2 axi_rst = 1'b1;
    #1;
    checks++;
    if ({axi_we, busy_o, coeff_ready_o} !== 3'b000) begin
      errors++; $display("FAIL rst_async: we/busy/ready=%b want 000", {axi_we, busy_o, coeff_ready_o});
    end
    checks++;
    if (axi_addr !== '0 || axi_data_w !== '0 || words_written_o !== 8'd0) begin
      errors++; $display("FAIL rst_async_data: addr=%0d data=%0h words=%0d want 0",
                         axi_addr, axi_data_w, words_written_o);
    end
    @(negedge axi_clk);
    axi_rst = 1'b0; coeff_valid_i = 1'b0;
    run_load(1'b0, 1'b1, 0, -1, 0, -1, -1, 500);
    checks++;
    if (wr_addr_q.size() == 0 || wr_addr_q[0] !== 0 || wr_data_q[0] !== src_words[0]) begin
      errors++; $display("FAIL rst_restart: first write addr=%0d want 0",
                         (wr_addr_q.size() != 0) ? wr_addr_q[0] : -1);
    end
    checks++;
    if (wr_addr_q.size() !== NCH || words_written_o !== 8'd24) begin
      errors++; $display("FAIL rst_reload: writes=%0d words=%0d want 24 24",
                         wr_addr_q.size(), words_written_o);
    end
  endtask

  task automatic test_start_during_busy();
    int bad;
    fill_src(1'b0);
    run_load(1'b0, 1'b1, 0, -1, 0, -1, 5, 500);
    bad = 0;
    for (int i = 0; i < wr_addr_q.size() && i < NCH; i++)
      if (wr_addr_q[i] !== i || wr_data_q[i] !== src_words[i]) bad++;
    checks++;
    if (bad !== 0 || wr_addr_q.size() !== NCH) begin
      errors++; $display("FAIL busy_start: writes=%0d wrong=%0d want 24 0", wr_addr_q.size(), bad);
    end
    checks++;
    if (done_cnt !== 1 || words_written_o !== 8'd24) begin
      errors++; $display("FAIL busy_start_done: done=%0d words=%0d want 1 24", done_cnt, words_written_o);
    end
    // spurious ack while idle must leave every output alone
    for (int k = 0; k < 3; k++) begin
      axi_ack = 1'b1;
      @(negedge axi_clk);
      checks++;
      if (axi_we !== 1'b0 || busy_o !== 1'b0 || done_o !== 1'b0 || coeff_ready_o !== 1'b0 ||
          words_written_o !== 8'd24 || axi_addr !== AW'(NCH - 1) ||
          axi_data_w !== src_words[NCH-1]) begin
        errors++; $display("FAIL idle_ack: we=%b busy=%b done=%b words=%0d addr=%0d want 0 0 0 24 23",
                           axi_we, busy_o, done_o, words_written_o, axi_addr);
      end
    end
    axi_ack = 1'b0;
  endtask

  initial begin
    test_reset();
    test_full_set();
    test_back_to_back();
    test_gapped();
    test_delayed_ack();
`ifdef COEFF_WR_TIMEOUT_EN
    test_timeout();
`endif
    test_reset_mid_load();
    test_start_during_busy();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
